icache_responder: RTL
=====================

// Module: icache_responder
// PURPOSE
//   Instruction-side responder on the datapath/cache interface: answers imemREN/imemaddr with ihit/imemload.
//   Direct-mapped, one-word-block instruction cache between the pipelined datapath fetch stage and the memory controller.
//   Hits return in the same cycle; misses run a fill FSM on the iREN/iaddr/iwait/iload memory-side handshake.
// PARAMETERS
//   SETS      16   number of frames; power of two, >=2; index width IDX_W = $clog2(SETS)
//   TAG_W     30-IDX_W   tag width, derived
// PORTS
//   CLK          in   1   system clock, rising edge
//   RST          in   1   asynchronous, active-high reset
//   imemREN      in   1   datapath fetch request
//   imemaddr     in   32  fetch byte address; [1:0] ignored
//   halt         in   1   datapath halted; suppresses new misses
//   ihit         out  1   requested word valid on imemload this cycle
//   imemload     out  32  instruction word
//   iREN         out  1   memory-side read request
//   iaddr        out  32  memory-side word address, [1:0]=2'b00
//   iwait        in   1   memory busy; iload valid in cycle iwait=0 while iREN=1
//   iload        in   32  memory read data
//   hit_count    out  32  hits counted (ICACHE_PERF_EN), else 0
//   miss_count   out  32  misses counted (ICACHE_PERF_EN), else 0
// BEHAVIOUR
//   Address split: tag=imemaddr[31:IDX_W+2], idx=imemaddr[IDX_W+1:2].
//   Reset (RST high, any time, async): all valid bits 0, state IDLE, miss_addr 0, counters 0;
//     outputs ihit=0, imemload=0, iREN=0, iaddr=0. Reset mid-fill abandons the fill; frame stays invalid.
//   Hit (comb): ihit = imemREN & !halt & state==IDLE & valid[idx] & tag==tag_arr[idx]; imemload=data[idx] when ihit, else 0.
//   FSM states: IDLE, FILL.
//     IDLE: on imemREN & !halt & !hit -> latch miss_addr={imemaddr[31:2],2'b00}; -> FILL.
//     FILL: iREN=1, iaddr=miss_addr, ihit=0.
//       iwait=1 -> stay in FILL.
//       iwait=0 -> write {valid=1,tag,iload} to frame of miss_addr; -> IDLE.
//   Miss latency: 1 cycle to enter FILL + memory latency; ihit asserts the cycle after the fill cycle, provided
//     imemaddr still matches.
//   imemaddr change during FILL (branch/jump redirect): fill completes to the latched miss_addr; new address
//     evaluated in IDLE afterwards. No cancellation.
//   halt asserted in FILL: current fill completes; no further misses launched; ihit forced 0 while halt=1.
//   Conflict miss: fill overwrites frame unconditionally (no write-back; I-side is read-only).
//   iREN is 0 in IDLE; iaddr is 0 in IDLE.
// CONFIGURATION
//   `ICACHE_PERF_EN defined: hit_count +1 per cycle ihit=1; miss_count +1 per IDLE->FILL transition;
//     both wrap at 2^32, cleared by RST.
//   Not defined: counter flops omitted, hit_count/miss_count tied to 32'h0; functional behaviour identical.
// STRUCTURE
//   cpu_types_pkg additions: icachef_t {tag, idx, bytoff} address view; icache_frame_t {valid, tag, data};
//     ICACHE_SETS constant; icache_state_t enum {IDLE, FILL}.
//   One sub-module: icache_frame_array (SETS frames, async-reset valid bits, 1 comb read port, 1 write port).
//   FSM, hit compare, counters in this module.
// TESTING
//   Reset then imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0x2002_0001 -> iREN=1,
//     iaddr=0x40 in FILL; ihit=1, imemload=0x2002_0001 next cycle.
//   Re-fetch 0x40 -> ihit same cycle, iREN stays 0; with PERF_EN hit_count=1, miss_count=1.
//   Conflict: fill 0x40, then 0x80 (same idx for SETS=16) -> miss, fill; return to 0x40 -> miss again.
//   Redirect: miss on 0x100, change imemaddr to 0x200 mid-FILL -> fill writes 0x100 frame; then 0x200 misses,
//     iaddr=0x200.
//   Reset asserted mid-FILL (iwait=1) -> iREN=0 immediately; refetch of same address misses.
//   halt=1 with imemREN=1 on a cold address -> no iREN, ihit=0, counters unchanged.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared types and constants for the instruction cache responder.
// Optional feature macro used by the top: ICACHE_PERF_EN (hit/miss counters).
package icache_responder_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  // Byte-address view of a fetch address for the default geometry.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // One direct-mapped frame: a single instruction word.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_responder_frame_array.sv
// Frame storage for the instruction cache: SETS frames, one combinational
// read port and one synchronous write port. Only the valid bits are reset;
// tag and data contents are don't-care until their frame is filled.
module icache_frame_array
  import icache_responder_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      data_d [SETS];

  // Next frame contents: a write replaces the addressed frame outright.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Valid bits clear asynchronously so a reset mid-fill leaves nothing stale.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data storage, no reset needed behind the valid bits.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache responder.
// Hits answer combinationally; misses run an IDLE/FILL sequence on the
// iREN/iaddr/iwait/iload memory handshake.
// Macro ICACHE_PERF_EN: enables hit_count/miss_count, otherwise tied to 0.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  logic [29:0]   miss_addr_q, miss_addr_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             tag_match;
  logic             wr_en;
  logic             unused_addr_bits;

  assign req_tag          = imemaddr[31:IDX_W+2];
  assign req_idx          = imemaddr[IDX_W+1:2];
  assign unused_addr_bits = ^imemaddr[1:0];

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (miss_addr_q[IDX_W-1:0]),
    .wr_tag   (miss_addr_q[29:IDX_W]),
    .wr_data  (iload)
  );

  // Hit path: only answered from IDLE, and never while the datapath is halted.
  always_comb begin
    tag_match = rd_valid && (rd_tag == req_tag);
    ihit      = imemREN && !halt && (state_q == IDLE) && tag_match;
    imemload  = ihit ? rd_data : 32'h0;
  end

  // Next state, miss latch and memory-side outputs.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !halt && !tag_match) begin
          miss_addr_d = imemaddr[31:2];
          state_d     = FILL;
        end
      end
      FILL: begin
        // The latched address is filled even if the fetch address moves on.
        iREN  = 1'b1;
        iaddr = {miss_addr_q, 2'b00};
        if (!iwait) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and miss address registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Performance counters: one hit per ihit cycle, one miss per fill launch.
  always_comb begin
    hit_count_d  = hit_count_q + 32'(ihit);
    miss_count_d = miss_count_q + 32'((state_q == IDLE) && (state_d == FILL));
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule
